// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, logic opcodes and the bitwise evaluation function.
// Imported by the logic result stage and its output FIFO.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Every 3-bit code is meaningful; NOT and PASS use operand A only.
    function automatic logic [ALU_WIDTH-1:0] logic_eval(
        input logic [ALU_WIDTH-1:0] a,
        input logic [ALU_WIDTH-1:0] b,
        input logic [2:0]           op
    );
        logic [ALU_WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_result_fifo.sv
// Two-entry output FIFO holding a result word plus its flags.
// Handshakes are evaluated here; in_ready depends only on the stored count.
module logic_result_fifo
    import alu_pkg::*;
#(
    parameter int W     = ALU_WIDTH + 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_data,
    output logic         o_in_ready,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_data
);

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic         w_push;
    logic         w_pop;
    logic [1:0]   r_count;
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [W-1:0] r_mem [2];

    assign o_in_ready  = (r_count < FULL_COUNT);
    assign o_out_valid = (r_count != 2'd0);
    assign w_push      = i_in_valid & o_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;
    assign o_data      = r_mem[r_rd_ptr];

    // Entries reset to zero so the head reads 0 straight out of reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            if (w_push && !w_pop)      r_count <= r_count + 2'd1;
            else if (w_pop && !w_push) r_count <= r_count - 2'd1;
        end
    end

endmodule

// File: rtl/logic_result_stage.sv
// Registered output stage for the 8-bit ALU logic path: opcode mux, flag generation,
// transaction counter and a 2-entry result buffer feeding the write-back bus.
module logic_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             P,
    output logic             N,
    output logic [15:0]      op_count
);

    logic [WIDTH-1:0] w_result;
    logic [WIDTH+2:0] w_wr_data;
    logic [WIDTH+2:0] w_head;
    logic             w_push;
    logic [15:0]      r_op_count;

    assign w_result  = logic_eval(A, B, op);
    // P is set when the result holds an even number of ones.
    assign w_wr_data = {w_result, (w_result == '0), ~^w_result, w_result[WIDTH-1]};
    assign w_push    = in_valid & in_ready;

    logic_result_fifo #(
        .W     (WIDTH + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (in_valid),
        .i_data      (w_wr_data),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_data      (w_head)
    );

    assign Y = w_head[WIDTH+2:3];
    assign Z = w_head[2];
    assign P = w_head[1];
    assign N = w_head[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= 16'd0;
        end else if (w_push) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;

endmodule

// File: tb/tb_logic_result_stage.sv
// Self-checking bench for logic_result_stage: scoreboard of expected head words plus
// per-scenario checks of handshake, latency, flags and op_count.
module tb_logic_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic [2:0]  op = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  Y;
    logic        Z, P, N;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [10:0] sb [$];

    logic_result_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .Z(Z), .P(P), .N(N), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        logic [7:0] y;
        case (o)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = ~(a & b);
            3'd3: y = ~(a | b);
            3'd4: y = a ^ b;
            3'd5: y = ~(a ^ b);
            3'd6: y = ~a;
            default: y = a;
        endcase
        return {y, (y == 8'h00), ~^y, y[7]};
    endfunction

    // Scoreboard: compare the head at each pop, enqueue the model result at each push.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow: pop with Y=%h but nothing expected", Y);
                end else begin
                    logic [10:0] exp_w;
                    exp_w = sb.pop_front();
                    pops++;
                    if ({Y, Z, P, N} !== exp_w)
                        begin
                            failures++;
                            $display("FAIL sb_head: got Y=%h ZPN=%b%b%b, want Y=%h ZPN=%b", Y, Z, P, N, exp_w[10:3], exp_w[2:0]);
                        end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(A, B, op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: %0d left, out_valid=%b, want 0 and 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'h0 || Y !== 8'h00 || {Z, P, N} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b op_count=%h Y=%h ZPN=%b%b%b, want 0 1 0000 00 000",
                     out_valid, in_ready, op_count, Y, Z, P, N);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_ops();
        logic [7:0] tbl [8] = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A, 8'hA5};
        out_ready = 1'b1;
        A = 8'hA5;
        B = 8'h3C;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            tick();
            checks++;
            if (out_valid !== 1'b1 || Y !== tbl[k]) begin
                failures++;
                $display("FAIL op_%0d: out_valid=%b Y=%h, want 1 %h", k, out_valid, Y, tbl[k]);
            end
        end
        drain();
        checks++;
        if (op_count !== 16'd8) begin
            failures++;
            $display("FAIL op_count_8: got %h want 0008", op_count);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 8'h12; B = 8'h34; op = 3'd1;
        tick();
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL prefill: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b op_count=%h, want 0 1 0000", out_valid, in_ready, op_count);
        end
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 8'hFF; B = 8'hFF; op = 3'd4;
        tick();
        checks++;
        if (Y !== 8'h00 || {Z, P, N} !== 3'b110) begin
            failures++;
            $display("FAIL flags_zero: Y=%h ZPN=%b%b%b, want 00 110", Y, Z, P, N);
        end
        A = 8'h80; B = 8'h5A; op = 3'd7;
        tick();
        checks++;
        if (Y !== 8'h80 || {Z, P, N} !== 3'b001) begin
            failures++;
            $display("FAIL flags_msb: Y=%h ZPN=%b%b%b, want 80 001", Y, Z, P, N);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = op_count;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 8'hC3; B = 8'h0F; op = 3'd0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first: in_ready=%b want 1", in_ready);
        end
        op = 3'd4;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: in_ready=%b want 0", in_ready);
        end
        op = 3'd3;
        repeat (3) tick();
        checks++;
        if (op_count !== base + 16'd2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: op_count=%h in_ready=%b, want %h 0", op_count, in_ready, base + 16'd2);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_pop_cycle: in_ready=%b want 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_after_pop: in_ready=%b want 1", in_ready);
        end
        tick();
        drain();
        checks++;
        if (op_count !== base + 16'd3) begin
            failures++;
            $display("FAIL bp_count: op_count=%h want %h", op_count, base + 16'd3);
        end
    endtask

    task automatic test_back_to_back();
        int start_pops;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 8'h5C; B = 8'h96; op = 3'd2;
        tick();
        start_pops = pops;
        for (int k = 0; k < 10; k++) begin
            A  = 8'($urandom);
            B  = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || dut.u_fifo.r_count !== 2'd1) begin
                failures++;
                $display("FAIL b2b_%0d: in_ready=%b out_valid=%b count=%0d, want 1 1 1", k, in_ready, out_valid, dut.u_fifo.r_count);
            end
        end
        checks++;
        if (pops - start_pops != 10) begin
            failures++;
            $display("FAIL b2b_pops: got %0d want 10", pops - start_pops);
        end
        drain();
    endtask

    task automatic test_op_count_wrap();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 8'h0F; B = 8'hF0; op = 3'd1;
        repeat (65534) tick();
        checks++;
        if (op_count !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_preload: op_count=%h want fffe", op_count);
        end
        tick();
        checks++;
        if (op_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_max: op_count=%h want ffff", op_count);
        end
        tick();
        checks++;
        if (op_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_zero: op_count=%h want 0000", op_count);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_reset_midstream();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_op_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
